// File: rtl/booth_mul32.sv
// rtl/booth_mul32.sv - sequential signed Booth multiplier, 64-bit {HI,LO} product
//
// Purpose: multiplies two WIDTH-bit two's-complement operands, one Booth step
//          per clock, behind a start/done handshake so control can stall on MUL.
// Build option: MUL_RADIX4_EN selects radix-4 recoding (WIDTH/2 steps, +/-2M
//          path); when undefined, radix-2 recoding (WIDTH steps).
// Ports:
//   clock  in   rising-edge clock
//   clear  in   asynchronous active-high reset
//   start  in   request, sampled only in IDLE
//   RegA   in   multiplicand (signed)
//   RegB   in   multiplier (signed)
//   busy   out  high while iterating
//   done   out  one-cycle pulse when Z is valid
//   Z      out  product, Z[2W-1:W]=HI, Z[W-1:0]=LO
module booth_mul32 #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic [WIDTH-1:0]   RegA,
  input  logic [WIDTH-1:0]   RegB,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] Z
);

`ifdef MUL_RADIX4_EN
  localparam int N  = WIDTH / 2;
  localparam int SH = 2;
`else
  localparam int N  = WIDTH;
  localparam int SH = 1;
`endif
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nxt;
  logic [WIDTH+1:0]    m, a, addend, sum, a_nxt;
  logic [WIDTH-1:0]    q, q_nxt;
  logic                qm1, qm1_nxt;
  logic [CW-1:0]       cnt;
  logic signed [2*WIDTH+2:0] cat, sh;

  // Booth recoding and one step of add + arithmetic shift. The accumulator
  // is two bits wider than the operand so that +/-2M and the most negative
  // operand never overflow.
  always_comb begin
    addend = '0;
`ifdef MUL_RADIX4_EN
    case ({q[1:0], qm1})
      3'b001, 3'b010: addend = m;
      3'b011:         addend = {m[WIDTH:0], 1'b0};
      3'b100:         addend = -{m[WIDTH:0], 1'b0};
      3'b101, 3'b110: addend = -m;
      default:        addend = '0;
    endcase
`else
    case ({q[0], qm1})
      2'b01:   addend = m;
      2'b10:   addend = -m;
      default: addend = '0;
    endcase
`endif
    sum = a + addend;
    cat = {sum, q, qm1};
    sh  = cat >>> SH;
    {a_nxt, q_nxt, qm1_nxt} = sh;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == CW'(1)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      m   <= '0;
      a   <= '0;
      q   <= '0;
      qm1 <= 1'b0;
      cnt <= '0;
      Z   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          m   <= {{2{RegA[WIDTH-1]}}, RegA};
          q   <= RegB;
          a   <= '0;
          qm1 <= 1'b0;
          cnt <= CW'(N);
        end
        RUN: begin
          a   <= a_nxt;
          q   <= q_nxt;
          qm1 <= qm1_nxt;
          cnt <= cnt - CW'(1);
          // Z is only written on the final step, never with partial products.
          if (cnt == CW'(1)) Z <= {a_nxt[WIDTH-1:0], q_nxt};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul32.sv
// tb/tb_booth_mul32.sv - directed self-checking bench for booth_mul32
module tb_booth_mul32;

`ifdef MUL_RADIX4_EN
  localparam int N = 16;
`else
  localparam int N = 32;
`endif

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [31:0] RegA, RegB;
  logic        busy, done;
  logic [63:0] Z;

  int checks = 0;
  int errs   = 0;

  booth_mul32 dut (
    .clock (clock),
    .clear (clear),
    .start (start),
    .RegA  (RegA),
    .RegB  (RegB),
    .busy  (busy),
    .done  (done),
    .Z     (Z)
  );

  always #5 clock = ~clock;

  // Issues one operation from IDLE (caller sits 1 time unit after an edge)
  // and returns once the FSM is back in IDLE.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] zr, output int lat, output int bcnt,
                        output logic dnext, output logic [63:0] z2);
    RegA  = a;
    RegB  = b;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat   = 0;
    bcnt  = busy ? 1 : 0;
    while (!done && lat < 200) begin
      @(posedge clock); #1;
      lat++;
      if (busy) bcnt++;
    end
    zr = Z;
    @(posedge clock); #1;
    dnext = done;
    z2    = Z;
  endtask

  task automatic test_reset;
    clear = 1'b1;
    start = 1'b0;
    RegA  = '0;
    RegB  = '0;
    #12;
    checks++; if (Z !== 64'd0)  begin errs++; $display("FAIL reset_z: got %h want %h", Z, 64'd0); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done: got %b want 0", done); end
    @(posedge clock); #1;
    clear = 1'b0;
  endtask

  task automatic test_products;
    logic [31:0] ta [7];
    logic [31:0] tb [7];
    logic [63:0] te [7];
    logic [63:0] zr, z2;
    int lat, bcnt;
    logic dn;
    ta[0] = 32'd7;          tb[0] = 32'd6;          te[0] = 64'h0000_0000_0000_002A;
    ta[1] = 32'hFFFF_FFFD;  tb[1] = 32'd5;          te[1] = 64'hFFFF_FFFF_FFFF_FFF1;
    ta[2] = 32'd5;          tb[2] = 32'hFFFF_FFFD;  te[2] = 64'hFFFF_FFFF_FFFF_FFF1;
    ta[3] = 32'h8000_0000;  tb[3] = 32'h8000_0000;  te[3] = 64'h4000_0000_0000_0000;
    ta[4] = 32'h7FFF_FFFF;  tb[4] = 32'h8000_0000;  te[4] = 64'hC000_0000_8000_0000;
    ta[5] = 32'hFFFF_FFFF;  tb[5] = 32'h7FFF_FFFF;  te[5] = 64'hFFFF_FFFF_8000_0001;
    ta[6] = 32'hFFFF_FFFF;  tb[6] = 32'hFFFF_FFFF;  te[6] = 64'h0000_0000_0000_0001;
    for (int i = 0; i < 7; i++) begin
      run_op(ta[i], tb[i], zr, lat, bcnt, dn, z2);
      checks++;
      if (zr !== te[i]) begin
        errs++;
        $display("FAIL product[%0d] %h*%h: got %h want %h", i, ta[i], tb[i], zr, te[i]);
      end
      checks++;
      if (lat !== N) begin
        errs++;
        $display("FAIL latency[%0d]: got %0d want %0d", i, lat, N);
      end
    end
  endtask

  task automatic test_handshake;
    logic [63:0] zr, z2;
    int lat, bcnt;
    logic dn;
    run_op(32'd9, 32'd10, zr, lat, bcnt, dn, z2);
    checks++; if (bcnt !== N) begin errs++; $display("FAIL busy_cycles: got %0d want %0d", bcnt, N); end
    checks++; if (dn !== 1'b0) begin errs++; $display("FAIL done_width: got %b want 0 one cycle later", dn); end
    checks++; if (z2 !== 64'd90) begin errs++; $display("FAIL z_hold: got %h want %h", z2, 64'd90); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    int t, gap;
    RegA  = 32'd3;
    RegB  = 32'd4;
    start = 1'b1;
    t = 0;
    while (!done && t < 200) begin @(posedge clock); #1; t++; end
    gap = 0;
    do begin @(posedge clock); #1; gap++; end while (!done && gap < 200);
    start = 1'b0;
    checks++; if (gap !== N + 2) begin errs++; $display("FAIL b2b_period: got %0d want %0d", gap, N + 2); end
    checks++; if (Z !== 64'd12) begin errs++; $display("FAIL b2b_z: got %h want %h", Z, 64'd12); end
    @(posedge clock); #1;
  endtask

  task automatic test_midrun_ignore;
    int lat, extra;
    RegA  = 32'd11;
    RegB  = 32'd13;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clock); #1;
      lat++;
      if (lat == N / 2) begin RegA = 32'd99; RegB = 32'd77; start = 1'b1; end
      if (lat == N / 2 + 1) begin start = 1'b0; RegA = 32'd5; RegB = 32'd5; end
    end
    checks++; if (Z !== 64'd143) begin errs++; $display("FAIL midrun_z: got %h want %h", Z, 64'd143); end
    checks++; if (lat !== N) begin errs++; $display("FAIL midrun_latency: got %0d want %0d", lat, N); end
    extra = 0;
    for (int k = 0; k < 2 * N; k++) begin @(posedge clock); #1; if (done) extra++; end
    checks++; if (extra !== 0) begin errs++; $display("FAIL midrun_extra_done: got %0d want 0", extra); end
  endtask

  task automatic test_clear_midrun;
    int extra, lat, bcnt;
    logic [63:0] zr, z2;
    logic dn;
    RegA  = 32'h1234_5678;
    RegB  = 32'h9ABC_DEF0;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (N / 2) begin @(posedge clock); #1; end
    clear = 1'b1;
    #1;
    checks++; if (Z !== 64'd0)   begin errs++; $display("FAIL clear_z: got %h want %h", Z, 64'd0); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL clear_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errs++; $display("FAIL clear_done: got %b want 0", done); end
    @(posedge clock); #1;
    clear = 1'b0;
    extra = 0;
    for (int k = 0; k < 2 * N; k++) begin @(posedge clock); #1; if (done) extra++; end
    checks++; if (extra !== 0) begin errs++; $display("FAIL clear_no_done: got %0d want 0", extra); end
    run_op(32'd2, 32'd3, zr, lat, bcnt, dn, z2);
    checks++; if (zr !== 64'd6) begin errs++; $display("FAIL after_clear_z: got %h want %h", zr, 64'd6); end
    checks++; if (lat !== N) begin errs++; $display("FAIL after_clear_latency: got %0d want %0d", lat, N); end
  endtask

  initial begin
    test_reset();
    test_products();
    test_handshake();
    test_back_to_back();
    test_midrun_ignore();
    test_clear_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end

endmodule
